// File: rtl/capture_ctrl.sv
// capture_ctrl: circular-buffer capture sequencing and single-channel dump to host
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2 = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrt_smpl,
  input  logic            run,
  input  logic            stop,
  input  logic            trig,
  input  logic [LOG2-1:0] trig_pos,
  input  logic            dump,
  input  logic [2:0]      ch_sel,
  input  logic [7:0]      rdataCH1,
  input  logic [7:0]      rdataCH2,
  input  logic [7:0]      rdataCH3,
  input  logic [7:0]      rdataCH4,
  input  logic [7:0]      rdataCH5,
  input  logic            resp_sent,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      resp,
  output logic            send_resp,
  output logic            armed,
  output logic            triggered,
  output logic            capture_done,
  output logic            dump_done
);
  typedef enum logic [2:0] {IDLE, ARMED, TRIG, DONE, DRD, DSEND, DWAIT} state_t;
  state_t r_state;
  logic [LOG2:0] r_pre_cnt, r_post_cnt, r_byte_cnt;
  logic [2:0] r_ch;
  logic [LOG2-1:0] r_waddr, r_raddr;
  logic [7:0] r_resp;
  logic r_send, r_done;
  logic [LOG2:0] w_tp, w_post_tgt, w_post_nxt, w_byte_nxt;
  logic [LOG2-1:0] w_waddr_nxt, w_raddr_nxt;
  logic [7:0] w_rdata;
  logic w_trig_ok, w_ch_ok;
  // trigger position is clamped so at least one post-trigger sample is kept
  assign w_tp = ({1'b0, trig_pos} >= (LOG2+1)'(ENTRIES)) ? (LOG2+1)'(ENTRIES-1) : {1'b0, trig_pos};
  assign w_post_tgt = (LOG2+1)'(ENTRIES) - w_tp;
  assign w_post_nxt = r_post_cnt + 1'b1;
  assign w_byte_nxt = r_byte_cnt + 1'b1;
  assign w_waddr_nxt = (r_waddr == LOG2'(ENTRIES-1)) ? '0 : r_waddr + 1'b1;
  assign w_raddr_nxt = (r_raddr == LOG2'(ENTRIES-1)) ? '0 : r_raddr + 1'b1;
  assign w_trig_ok = trig & wrt_smpl & (r_pre_cnt >= w_tp);
  assign w_ch_ok = (ch_sel >= 3'd1) && (ch_sel <= 3'd5);
  assign w_rdata = (r_ch == 3'd1) ? rdataCH1 :
                   (r_ch == 3'd2) ? rdataCH2 :
                   (r_ch == 3'd3) ? rdataCH3 :
                   (r_ch == 3'd4) ? rdataCH4 : rdataCH5;
  assign we = wrt_smpl & ((r_state == ARMED) | (r_state == TRIG));
  assign waddr = r_waddr;
  assign raddr = r_raddr;
  assign resp = r_resp;
  assign send_resp = r_send;
  assign dump_done = r_done;
  assign armed = (r_state == ARMED);
  assign triggered = (r_state == TRIG);
  assign capture_done = (r_state == DONE) | (r_state == DRD) | (r_state == DSEND) | (r_state == DWAIT);
  // capture/dump sequencer; stop aborts everything but keeps waddr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pre_cnt <= '0;
      r_post_cnt <= '0;
      r_byte_cnt <= '0;
      r_ch <= '0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_resp <= '0;
      r_send <= 1'b0;
      r_done <= 1'b0;
    end else if (stop) begin
      r_state <= IDLE;
      r_pre_cnt <= '0;
      r_post_cnt <= '0;
      r_byte_cnt <= '0;
      r_ch <= '0;
      r_raddr <= '0;
      r_resp <= '0;
      r_send <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_send <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (run) begin
            r_state <= ARMED;
            r_waddr <= '0;
            r_pre_cnt <= '0;
            r_post_cnt <= '0;
          end else if ((r_state == DONE) && dump && w_ch_ok) begin
            r_ch <= ch_sel;
            r_raddr <= r_waddr;
            r_byte_cnt <= '0;
            r_state <= DRD;
          end
        end
        ARMED: begin
          if (wrt_smpl) begin
            r_waddr <= w_waddr_nxt;
            r_pre_cnt <= (r_pre_cnt == (LOG2+1)'(ENTRIES)) ? r_pre_cnt : r_pre_cnt + 1'b1;
            if (w_trig_ok) begin
              r_post_cnt <= (LOG2+1)'(1);
              r_state <= (w_post_tgt == (LOG2+1)'(1)) ? DONE : TRIG;
            end
          end
        end
        TRIG: begin
          if (wrt_smpl) begin
            r_waddr <= w_waddr_nxt;
            r_post_cnt <= w_post_nxt;
            if (w_post_nxt == w_post_tgt) r_state <= DONE;
          end
        end
        DRD: r_state <= DSEND;
        DSEND: begin
          r_resp <= w_rdata;
          r_send <= 1'b1;
          r_state <= DWAIT;
        end
        DWAIT: begin
          if (resp_sent) begin
            r_raddr <= w_raddr_nxt;
            r_byte_cnt <= w_byte_nxt;
            r_done <= (w_byte_nxt == (LOG2+1)'(ENTRIES));
            r_state <= (w_byte_nxt == (LOG2+1)'(ENTRIES)) ? DONE : DRD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed checks of capture sequencing, trigger clamping, dump, stop and reset
module tb_capture_ctrl;
  logic clk, rst, wrt_smpl, run, stop, trig, dump, resp_sent;
  logic [8:0] trig_pos;
  logic [2:0] ch_sel;
  logic [7:0] rd1, rd2, rd3, rd4, rd5;
  logic we, send_resp, armed, triggered, capture_done, dump_done;
  logic [8:0] waddr, raddr;
  logic [7:0] resp;
  int n_cmp = 0;
  int n_bad = 0;
  capture_ctrl #(.ENTRIES(384), .LOG2(9)) dut (
    .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl), .run(run), .stop(stop), .trig(trig),
    .trig_pos(trig_pos), .dump(dump), .ch_sel(ch_sel),
    .rdataCH1(rd1), .rdataCH2(rd2), .rdataCH3(rd3), .rdataCH4(rd4), .rdataCH5(rd5),
    .resp_sent(resp_sent), .we(we), .waddr(waddr), .raddr(raddr), .resp(resp),
    .send_resp(send_resp), .armed(armed), .triggered(triggered),
    .capture_done(capture_done), .dump_done(dump_done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] ram(input int ch, input logic [8:0] a);
    return 8'(int'(a) * 3 + ch * 37);
  endfunction
  // registered RAM read model, one cycle latency, distinct contents per channel
  always_ff @(posedge clk) begin
    rd1 <= ram(1, raddr);
    rd2 <= ram(2, raddr);
    rd3 <= ram(3, raddr);
    rd4 <= ram(4, raddr);
    rd5 <= ram(5, raddr);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic smpl(input bit t);
    wrt_smpl = 1'b1;
    trig = t;
    step();
    wrt_smpl = 1'b0;
    trig = 1'b0;
  endtask
  initial begin
    int k;
    rst = 1'b1; wrt_smpl = 0; run = 0; stop = 0; trig = 0; dump = 0; resp_sent = 0;
    trig_pos = '0; ch_sel = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_flags", {we, send_resp, armed, triggered, capture_done, dump_done}, 0);
    chk("reset_addr", {waddr, raddr, resp}, 0);
    // trigger position 100, trigger at pre-count 150
    trig_pos = 9'd100;
    run = 1'b1; wrt_smpl = 1'b1;
    step();
    run = 1'b0; wrt_smpl = 1'b0;
    chk("run_armed", {armed, triggered, capture_done}, 3'b100);
    chk("run_nowrite", waddr, 0);
    wrt_smpl = 1'b1; #1;
    chk("we_armed", we, 1);
    for (int s = 0; s < 434; s++) begin
      smpl(s == 150);
      if (s == 149) chk("tp100_pre", {armed, triggered}, 2'b10);
      if (s == 150) chk("tp100_trig", {armed, triggered}, 2'b01);
      if (s == 432) chk("tp100_last_trig", {triggered, capture_done}, 2'b10);
      if (s == 433) chk("tp100_done", {triggered, capture_done}, 2'b01);
    end
    chk("tp100_start", waddr, 50);
    wrt_smpl = 1'b1; #1;
    chk("we_done", we, 0);
    step();
    wrt_smpl = 1'b0;
    chk("waddr_hold_done", waddr, 50);
    // invalid channel is ignored
    dump = 1'b1; ch_sel = 3'd0;
    step();
    dump = 1'b0;
    step(); step();
    chk("inv_ch", {send_resp, raddr}, 0);
    chk("inv_ch_state", capture_done, 1);
    // dump channel 3, resp_sent 3 cycles after each send_resp
    dump = 1'b1; ch_sel = 3'd3;
    step();
    dump = 1'b0; ch_sel = 3'd0;
    chk("dump_raddr_start", raddr, 50);
    for (int i = 0; i < 384; i++) begin
      k = 0;
      while (!send_resp && k < 8) begin step(); k++; end
      chk("send_lat", k, 2);
      chk("dump_raddr", raddr, (50 + i) % 384);
      chk("dump_resp", resp, ram(3, 9'((50 + i) % 384)));
      step();
      chk("send_pulse", send_resp, 0);
      step(); step();
      chk("resp_hold", resp, ram(3, 9'((50 + i) % 384)));
      resp_sent = 1'b1;
      step();
      resp_sent = 1'b0;
      chk("dump_done_lvl", dump_done, (i == 383) ? 1 : 0);
    end
    step();
    chk("dump_done_pulse", {dump_done, capture_done}, 2'b01);
    // stop during DWAIT wins over resp_sent
    dump = 1'b1; ch_sel = 3'd1;
    step();
    dump = 1'b0;
    step(); step();
    chk("ch1_send", {send_resp, resp}, {1'b1, ram(1, 9'd50)});
    step();
    stop = 1'b1; resp_sent = 1'b1;
    step();
    stop = 1'b0; resp_sent = 1'b0;
    chk("stop_flags", {send_resp, armed, triggered, capture_done, dump_done}, 0);
    chk("stop_regs", {raddr, resp}, 0);
    chk("stop_waddr", waddr, 50);
    resp_sent = 1'b1;
    step();
    resp_sent = 1'b0;
    step();
    chk("stop_late_sent", {send_resp, dump_done, capture_done, raddr}, 0);
    // early trigger ignored; stray run and dump during capture ignored
    trig_pos = 9'd200;
    run = 1'b1;
    step();
    run = 1'b0;
    chk("et_armed", {armed, waddr}, {1'b1, 9'd0});
    for (int s = 0; s < 434; s++) begin
      run = (s == 100);
      dump = (s == 120);
      ch_sel = 3'd2;
      smpl(s == 50 || s == 250);
      run = 1'b0; dump = 1'b0;
      if (s == 50) chk("et_early_ignored", {armed, triggered}, 2'b10);
      if (s == 120) chk("et_dump_ignored", {armed, capture_done}, 2'b10);
      if (s == 249) chk("et_pre", armed, 1);
      if (s == 250) chk("et_trig", triggered, 1);
      if (s == 432) chk("et_last_trig", {triggered, capture_done}, 2'b10);
      if (s == 433) chk("et_done", {triggered, capture_done}, 2'b01);
    end
    chk("et_waddr", waddr, 50);
    // trig_pos 383 and 500 both go straight from ARMED to DONE
    for (int r = 0; r < 2; r++) begin
      trig_pos = (r == 0) ? 9'd383 : 9'd500;
      run = 1'b1;
      step();
      run = 1'b0;
      chk("edge_armed", {armed, capture_done, waddr}, {2'b10, 9'd0});
      for (int s = 0; s < 384; s++) begin
        smpl(s >= 382);
        if (s == 382) chk("edge_pre_ignored", {armed, triggered, capture_done}, 3'b100);
        if (s == 383) chk("edge_done", {armed, triggered, capture_done}, 3'b001);
      end
      chk("edge_waddr", waddr, 0);
    end
    // asynchronous reset in TRIG
    trig_pos = 9'd0;
    run = 1'b1;
    step();
    run = 1'b0;
    for (int s = 0; s < 10; s++) smpl(s == 5);
    chk("rst_pre_trig", {triggered, waddr}, {1'b1, 9'd10});
    #1 rst = 1'b1;
    #1;
    chk("rst_async_flags", {we, send_resp, armed, triggered, capture_done, dump_done}, 0);
    chk("rst_async_addr", {waddr, raddr, resp}, 0);
    step();
    rst = 1'b0;
    run = 1'b1;
    step();
    run = 1'b0;
    chk("rst_rerun", {armed, waddr}, {1'b1, 9'd0});
    smpl(1'b0);
    chk("rst_rerun_write", waddr, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
